hazard_stall_ctrl: RTL and testbench

//  Stall/flush controller for the 5-stage pipeline registers (F/D, D/E, E/M).

---
 rtl/hazard_stall_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: Tuse/Tnew data-hazard detection, mult/div busy
// sequencing, and a saturating stall-cycle counter for performance readback.

module hazard_stall_ctrl_chk (
    input logic clk,
    input logic reset,
    input logic E_md_start,
    input logic md_busy
);

    // A new mult/div start while the unit is busy means D failed to stall.
    md_start_while_busy: assert property (@(posedge clk) disable iff (reset)
        !(E_md_start && md_busy))
        else $error("hazard_stall_ctrl: E_md_start while md_busy, start ignored");

endmodule

module hazard_stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       D_rs,
    input  logic [4:0]       D_rt,
    input  logic [1:0]       D_tuse_rs,
    input  logic [1:0]       D_tuse_rt,
    input  logic             D_is_md,
    input  logic [4:0]       E_waddr,
    input  logic [1:0]       E_tnew,
    input  logic [4:0]       M_waddr,
    input  logic [1:0]       M_tnew,
    input  logic             E_md_start,
    input  logic             E_md_is_div,
    output logic             pc_we,
    output logic             d_we,
    output logic             e_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    logic [3:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_rs, stall_rt, stall_md, stall;

    assign md_busy = (md_cnt_q != 4'd0);

    // Hazard detection; register 0 is never a real dependency.
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        if (D_rs != 5'd0) begin
            stall_rs = ((D_rs == E_waddr) && (E_tnew > D_tuse_rs)) ||
                       ((D_rs == M_waddr) && (M_tnew > D_tuse_rs));
        end else begin
            stall_rs = 1'b0;
        end
        if (D_rt != 5'd0) begin
            stall_rt = ((D_rt == E_waddr) && (E_tnew > D_tuse_rt)) ||
                       ((D_rt == M_waddr) && (M_tnew > D_tuse_rt));
        end else begin
            stall_rt = 1'b0;
        end
        stall_md = D_is_md && (md_busy || E_md_start);
        if (reset) begin
            stall = 1'b0;
        end else begin
            stall = stall_rs | stall_rt | stall_md;
        end
    end

    assign pc_we   = ~stall;
    assign d_we    = ~stall;
    assign e_flush = stall;

    // Busy down-counter; a start while busy is ignored and the count runs on.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (E_md_start && !md_busy) begin
            md_cnt_d = E_md_is_div ? DIV_LD : MULT_LD;
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end else begin
            md_cnt_d = md_cnt_q;
        end
    end

    // Saturating stall-cycle counter, one increment per stalled cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

`ifndef SYNTHESIS
    hazard_stall_ctrl_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .E_md_start (E_md_start),
        .md_busy    (md_busy)
    );
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a 32-bit instance for the main scenarios
// and a 4-bit-counter instance for saturation.

module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_waddr, M_waddr;
    logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic        D_is_md, E_md_start, E_md_is_div;
    logic        pc_we0, d_we0, e_flush0, md_busy0;
    logic [31:0] stall_cnt0;
    logic        pc_we1, d_we1, e_flush1, md_busy1;
    logic [3:0]  stall_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        bit          sel;
        logic        stall;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_stall_ctrl dut0 (
        .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md),
        .E_waddr(E_waddr), .E_tnew(E_tnew), .M_waddr(M_waddr), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
        .pc_we(pc_we0), .d_we(d_we0), .e_flush(e_flush0), .md_busy(md_busy0),
        .stall_cnt(stall_cnt0)
    );

    hazard_stall_ctrl #(.CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md),
        .E_waddr(E_waddr), .E_tnew(E_tnew), .M_waddr(M_waddr), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
        .pc_we(pc_we1), .d_we(d_we1), .e_flush(e_flush1), .md_busy(md_busy1),
        .stall_cnt(stall_cnt1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pops one expectation per cycle and compares mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (!e.sel) begin
                check_eq({e.tag, ".e_flush"}, 32'(e_flush0), 32'(e.stall));
                check_eq({e.tag, ".pc_we"},   32'(pc_we0),   32'(!e.stall));
                check_eq({e.tag, ".d_we"},    32'(d_we0),    32'(!e.stall));
                check_eq({e.tag, ".md_busy"}, 32'(md_busy0), 32'(e.busy));
                check_eq({e.tag, ".cnt"},     stall_cnt0,    e.cnt);
            end else begin
                check_eq({e.tag, ".e_flush4"}, 32'(e_flush1),   32'(e.stall));
                check_eq({e.tag, ".pc_we4"},   32'(pc_we1),     32'(!e.stall));
                check_eq({e.tag, ".md_busy4"}, 32'(md_busy1),   32'(e.busy));
                check_eq({e.tag, ".cnt4"},     32'(stall_cnt1), e.cnt);
            end
        end
    end

    task automatic idle();
        reset = 1'b0; D_rs = 5'd0; D_rt = 5'd0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
        D_is_md = 1'b0; E_waddr = 5'd0; E_tnew = 2'd0; M_waddr = 5'd0; M_tnew = 2'd0;
        E_md_start = 1'b0; E_md_is_div = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input bit sel, input logic stall,
                              input logic busy, input logic [31:0] cnt);
        exp_t e;
        e.tag = tag; e.sel = sel; e.stall = stall; e.busy = busy; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        reset = 1'b1;
        // Reset with a live hazard present: stall must be masked.
        next(); idle(); reset = 1'b1; D_rs = 5'd8; D_tuse_rs = 2'd1; E_waddr = 5'd8; E_tnew = 2'd2;
        expect_out("rst_mask", 1'b0, 1'b0, 1'b0, 32'd0);
        next(); idle(); expect_out("post_rst", 1'b0, 1'b0, 1'b0, 32'd0);

        // lw in E against rs use in D, then the M-stage case that no longer stalls.
        next(); idle(); D_rs = 5'd8; D_tuse_rs = 2'd1; E_waddr = 5'd8; E_tnew = 2'd2;
        expect_out("lw_e", 1'b0, 1'b1, 1'b0, 32'd0);
        next(); idle(); D_rs = 5'd8; D_tuse_rs = 2'd1; M_waddr = 5'd8; M_tnew = 2'd1;
        expect_out("lw_m", 1'b0, 1'b0, 1'b0, 32'd1);
        next(); idle(); D_rt = 5'd9; D_tuse_rt = 2'd0; M_waddr = 5'd9; M_tnew = 2'd1;
        expect_out("rt_m", 1'b0, 1'b1, 1'b0, 32'd1);
        next(); idle(); expect_out("idle1", 1'b0, 1'b0, 1'b0, 32'd2);

        // $zero dependency never stalls.
        next(); idle(); D_rs = 5'd0; D_tuse_rs = 2'd1; E_waddr = 5'd0; E_tnew = 2'd2;
        expect_out("zero_reg", 1'b0, 1'b0, 1'b0, 32'd2);
        next(); idle(); expect_out("zero_cnt", 1'b0, 1'b0, 1'b0, 32'd2);

        // mult start with mfhi in D: 6 stalled cycles.
        next(); idle(); E_md_start = 1'b1; D_is_md = 1'b1;
        expect_out("mult_start", 1'b0, 1'b1, 1'b0, 32'd2);
        for (int i = 1; i <= 5; i++) begin
            next(); idle(); D_is_md = 1'b1;
            expect_out($sformatf("mult_busy%0d", i), 1'b0, 1'b1, 1'b1, 32'(2 + i));
        end
        next(); idle(); D_is_md = 1'b1;
        expect_out("mult_done", 1'b0, 1'b0, 1'b0, 32'd8);

        // Full div occupancy without an md instruction in D.
        next(); idle(); E_md_start = 1'b1; E_md_is_div = 1'b1;
        expect_out("div_start", 1'b0, 1'b0, 1'b0, 32'd8);
        for (int i = 1; i <= 10; i++) begin
            next(); idle();
            expect_out($sformatf("div_busy%0d", i), 1'b0, 1'b0, 1'b1, 32'd8);
        end
        next(); idle(); expect_out("div_done", 1'b0, 1'b0, 1'b0, 32'd8);

        // div interrupted by reset on its 4th busy cycle.
        next(); idle(); E_md_start = 1'b1; E_md_is_div = 1'b1;
        expect_out("div2_start", 1'b0, 1'b0, 1'b0, 32'd8);
        for (int i = 1; i <= 3; i++) begin
            next(); idle(); D_is_md = 1'b1;
            expect_out($sformatf("div2_busy%0d", i), 1'b0, 1'b1, 1'b1, 32'(8 + i - 1));
        end
        next(); idle(); reset = 1'b1; D_is_md = 1'b1;
        expect_out("div2_rst", 1'b0, 1'b0, 1'b1, 32'd11);
        next(); idle(); D_is_md = 1'b1;
        expect_out("div2_after", 1'b0, 1'b0, 1'b0, 32'd0);

        // Data and md hazards together count once.
        next(); idle(); E_md_start = 1'b1; D_is_md = 1'b1;
        D_rs = 5'd8; D_tuse_rs = 2'd1; E_waddr = 5'd8; E_tnew = 2'd2;
        expect_out("both", 1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            next(); idle();
            expect_out($sformatf("both_drain%0d", i), 1'b0, 1'b0, 1'b1, 32'd1);
        end
        next(); idle(); expect_out("both_done", 1'b0, 1'b0, 1'b0, 32'd1);

        // Saturation on the 4-bit instance.
        next(); idle(); reset = 1'b1;
        expect_out("sat_rst", 1'b1, 1'b0, 1'b0, 32'd1);
        for (int i = 0; i < 18; i++) begin
            next(); idle(); D_rs = 5'd8; D_tuse_rs = 2'd1; E_waddr = 5'd8; E_tnew = 2'd2;
            expect_out($sformatf("sat%0d", i), 1'b1, 1'b1, 1'b0, 32'((i < 15) ? i : 15));
        end
        next(); idle(); expect_out("sat_hold", 1'b1, 1'b0, 1'b0, 32'd15);

        @(negedge clk);
        #1;
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
